fft_frame_sequencer: RTL and testbench

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

---
 rtl/fft_frame_sequencer_if.sv | 66 ++++++
 rtl/fft_frame_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_sequencer_if
// Brief    : Bundle of upstream, FFT-core, downstream and status signals
//            used by the FFT frame sequencer.
//            master = sequencer side, slave = surrounding system side.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_frame_sequencer_if #(
  parameter int W = 16
);
  // upstream beat interface
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_d0;
  logic [W-1:0] in_d1;
  logic [W-1:0] in_d2;
  logic [W-1:0] in_d3;
  // FFT core input side
  logic         core_next;
  logic [W-1:0] core_x0;
  logic [W-1:0] core_x1;
  logic [W-1:0] core_x2;
  logic [W-1:0] core_x3;
  // FFT core output side
  logic         core_next_out;
  logic [W-1:0] core_y0;
  logic [W-1:0] core_y1;
  logic [W-1:0] core_y2;
  logic [W-1:0] core_y3;
  // downstream beat interface
  logic         out_valid;
  logic         out_first;
  logic         out_last;
  logic [W-1:0] out_d0;
  logic [W-1:0] out_d1;
  logic [W-1:0] out_d2;
  logic [W-1:0] out_d3;
  // status
  logic         clr_err;
  logic         underrun;
  logic         overrun;
  logic [7:0]   frames_in;
  logic [7:0]   frames_out;

  modport master (
    input  in_valid, in_d0, in_d1, in_d2, in_d3,
    input  core_next_out, core_y0, core_y1, core_y2, core_y3,
    input  clr_err,
    output in_ready,
    output core_next, core_x0, core_x1, core_x2, core_x3,
    output out_valid, out_first, out_last, out_d0, out_d1, out_d2, out_d3,
    output underrun, overrun, frames_in, frames_out
  );

  modport slave (
    output in_valid, in_d0, in_d1, in_d2, in_d3,
    output core_next_out, core_y0, core_y1, core_y2, core_y3,
    output clr_err,
    input  in_ready,
    input  core_next, core_x0, core_x1, core_x2, core_x3,
    input  out_valid, out_first, out_last, out_d0, out_d1, out_d2, out_d3,
    input  underrun, overrun, frames_in, frames_out
  );
endinterface
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_sequencer
// Brief    : Feeds fixed-length frames of 4-word beats into a streaming FFT
//            core with a guaranteed minimum spacing between frame starts, and
//            reframes the core output into first/last-qualified beats.
//            Input and output paths run independently of each other.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_sequencer #(
  parameter int W           = 16,
  parameter int FRAME_BEATS = 512,
  parameter int MIN_GAP     = 5140
) (
  input  wire logic              clk,
  input  wire logic              reset,
  fft_frame_sequencer_if.master  bus
);

  localparam int             c_BEAT_W    = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam [c_BEAT_W-1:0]  c_LAST_BEAT = c_BEAT_W'(FRAME_BEATS - 1);
  localparam [15:0]          c_GAP_MAX   = 16'(MIN_GAP);
  localparam [15:0]          c_GAP_THR   = 16'(MIN_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_BEAT_W-1:0] r_beat_cnt;
  logic [15:0]         r_gap_cnt;
  logic                w_gap_ok;
  logic                w_start;
  logic                w_last_beat;
  logic                w_in_ready;
  logic                w_core_next;
  logic [4*W-1:0]      r_core_x;
  logic                r_underrun;
  logic [7:0]          r_frames_in;

  logic                r_cno_d;
  logic                w_rise;
  logic                r_cap_active;
  logic [c_BEAT_W-1:0] r_cap_cnt;
  logic                r_out_valid;
  logic                r_out_first;
  logic                r_out_last;
  logic [4*W-1:0]      r_out_d;
  logic                r_overrun;
  logic [7:0]          r_frames_out;

  assign w_gap_ok = (r_gap_cnt >= c_GAP_THR);
  assign w_rise   = bus.core_next_out && !r_cno_d;

  // Next-state and handshake decode; GAP hands straight to the start check so
  // core_next spacing is exactly MIN_GAP when data is waiting.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_last_beat = 1'b0;
    w_in_ready  = (r_state == S_LOAD);
    w_core_next = (r_state == S_LOAD) && (r_beat_cnt == '0);
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && w_gap_ok) begin
          w_state_nxt = S_LOAD;
          w_start     = 1'b1;
        end
      end
      S_LOAD: begin
        if (r_beat_cnt == c_LAST_BEAT) begin
          w_state_nxt = S_GAP;
          w_last_beat = 1'b1;
        end
      end
      S_GAP: begin
        if (w_gap_ok) begin
          if (bus.in_valid) begin
            w_state_nxt = S_LOAD;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and beat position within the frame being loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start)
        r_beat_cnt <= '0;
      else if (r_state == S_LOAD)
        r_beat_cnt <= r_beat_cnt + c_BEAT_W'(1);
    end
  end

  // Cycles since the last frame start; reads 0 in the core_next cycle and
  // starts saturated so the first frame after reset need not wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_gap_cnt <= c_GAP_MAX;
    else if (w_start)
      r_gap_cnt <= '0;
    else if (r_gap_cnt < c_GAP_MAX)
      r_gap_cnt <= r_gap_cnt + 16'd1;
  end

  // Input datapath: register accepted beats, zero-fill missing ones, count frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_x    <= '0;
      r_underrun  <= 1'b0;
      r_frames_in <= '0;
    end else begin
      if (w_in_ready && bus.in_valid)
        r_core_x <= {bus.in_d3, bus.in_d2, bus.in_d1, bus.in_d0};
      else
        r_core_x <= '0;
      if (w_in_ready && !bus.in_valid)
        r_underrun <= 1'b1;
      else if (bus.clr_err)
        r_underrun <= 1'b0;
      if (w_last_beat)
        r_frames_in <= r_frames_in + 8'd1;
    end
  end

  // Output capture: sample core_y for FRAME_BEATS cycles after each rising
  // edge of core_next_out; a fresh edge mid-capture restarts at beat 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cno_d      <= 1'b0;
      r_cap_active <= 1'b0;
      r_cap_cnt    <= '0;
      r_out_valid  <= 1'b0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_d      <= '0;
      r_overrun    <= 1'b0;
      r_frames_out <= '0;
    end else begin
      r_cno_d     <= bus.core_next_out;
      r_out_valid <= r_cap_active;
      r_out_first <= r_cap_active && (r_cap_cnt == '0);
      r_out_last  <= r_cap_active && (r_cap_cnt == c_LAST_BEAT);
      r_out_d     <= r_cap_active ? {bus.core_y3, bus.core_y2, bus.core_y1, bus.core_y0} : '0;
      if (w_rise) begin
        r_cap_active <= 1'b1;
        r_cap_cnt    <= '0;
      end else if (r_cap_active) begin
        if (r_cap_cnt == c_LAST_BEAT)
          r_cap_active <= 1'b0;
        r_cap_cnt <= r_cap_cnt + c_BEAT_W'(1);
      end
      if (w_rise && r_cap_active)
        r_overrun <= 1'b1;
      else if (bus.clr_err)
        r_overrun <= 1'b0;
      if (r_out_last)
        r_frames_out <= r_frames_out + 8'd1;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.core_next  = w_core_next;
  assign bus.core_x0    = r_core_x[0*W +: W];
  assign bus.core_x1    = r_core_x[1*W +: W];
  assign bus.core_x2    = r_core_x[2*W +: W];
  assign bus.core_x3    = r_core_x[3*W +: W];
  assign bus.out_valid  = r_out_valid;
  assign bus.out_first  = r_out_first;
  assign bus.out_last   = r_out_last;
  assign bus.out_d0     = r_out_d[0*W +: W];
  assign bus.out_d1     = r_out_d[1*W +: W];
  assign bus.out_d2     = r_out_d[2*W +: W];
  assign bus.out_d3     = r_out_d[3*W +: W];
  assign bus.underrun   = r_underrun;
  assign bus.overrun    = r_overrun;
  assign bus.frames_in  = r_frames_in;
  assign bus.frames_out = r_frames_out;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_sequencer
// Brief    : Scoreboard bench for fft_frame_sequencer. The driver advances a
//            frame-window reference model and queues the expected per-cycle
//            response; an independent monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_sequencer;

  localparam int W  = 16;
  localparam int FB = 512;
  localparam int MG = 5140;
  localparam longint FAR = -1000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fft_frame_sequencer_if #(.W(W)) bus ();

  fft_frame_sequencer #(
    .W(W), .FRAME_BEATS(FB), .MIN_GAP(MG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic           rdy;
    logic           nxt;
    logic [4*W-1:0] x;
    logic           und;
    logic           ovr;
    logic [7:0]     fin;
    logic [7:0]     fout;
    logic           ov;
    logic           of;
    logic           ol;
    logic [4*W-1:0] od;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mon_cyc  = 0;
  exp_t me;

  // reference model state: frames are windows on an absolute cycle axis
  longint         m_cyc = 0;
  longint         m_C = FAR;        // cycle of last frame start
  longint         m_cs = FAR;       // cycle of last core_next_out rise
  bit             m_prev_rst = 1'b1;
  bit             m_prev_valid = 1'b0;
  bit             m_prev_rdy = 1'b0;
  logic [4*W-1:0] m_prev_d = '0;
  bit             m_prev_cno = 1'b0;
  bit             m_und = 1'b0;
  bit             m_ovr = 1'b0;
  logic [7:0]     m_fin = '0;
  logic [7:0]     m_fout = '0;
  bit             m_po_v = 1'b0, m_po_f = 1'b0, m_po_l = 1'b0;
  logic [4*W-1:0] m_po_d = '0;
  int             m_j = 0;

  // stimulus knobs
  bit     g_rand_data = 1'b0;
  bit     g_y_rand = 1'b0;
  longint g_drop_beat = -1;
  bit     g_clr_on_drop = 1'b0;
  longint g_reset_beat = -1;
  bit     g_reset_hit = 1'b0;

  task automatic chk(input string nm, input logic [4*W-1:0] act, input logic [4*W-1:0] exv);
    n_checks++;
    if (act === exv) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, mon_cyc, act, exv);
  endtask

  // one clock of stimulus plus the model's expectation for that cycle
  task automatic step(input bit r_in, input bit v_in, input bit c_in, input bit cn);
    exp_t e;
    bit r, v, c, start, rdy, in_win, rise;
    longint c_start, beat, sbeat;
    logic [4*W-1:0] d, y;
    @(posedge clk);
    #1;
    m_cyc++;
    r = r_in; v = v_in; c = c_in;
    c_start = m_C;
    start = !m_prev_rst && m_prev_valid && (m_cyc > m_C + FB) && (m_cyc >= m_C + MG);
    if (start) c_start = m_cyc;
    rdy  = (m_cyc >= c_start) && (m_cyc < c_start + FB);
    beat = m_cyc - c_start;
    if (rdy && beat == g_reset_beat) begin r = 1'b1; g_reset_hit = 1'b1; end
    if (rdy && beat == g_drop_beat) begin v = 1'b0; c = c | g_clr_on_drop; end
    for (int k = 0; k < 4; k++) begin
      d[k*W +: W] = g_rand_data ? W'($urandom) : W'(4 * m_j + k);
      y[k*W +: W] = g_y_rand ? W'($urandom) : W'(m_cyc + 1000 * k);
    end
    reset = r;
    bus.in_valid = v;
    bus.in_d0 = d[0*W +: W]; bus.in_d1 = d[1*W +: W];
    bus.in_d2 = d[2*W +: W]; bus.in_d3 = d[3*W +: W];
    bus.clr_err = c;
    bus.core_next_out = cn;
    bus.core_y0 = y[0*W +: W]; bus.core_y1 = y[1*W +: W];
    bus.core_y2 = y[2*W +: W]; bus.core_y3 = y[3*W +: W];
    e = '0;
    if (r) begin
      q.push_back(e);
      m_C = FAR; m_cs = FAR; m_prev_rst = 1'b1;
      m_prev_valid = 1'b0; m_prev_rdy = 1'b0; m_prev_d = '0; m_prev_cno = 1'b0;
      m_und = 1'b0; m_ovr = 1'b0; m_fin = '0; m_fout = '0;
      m_po_v = 1'b0; m_po_f = 1'b0; m_po_l = 1'b0; m_po_d = '0; m_j = 0;
    end else begin
      m_C = c_start;
      e.rdy = rdy;
      e.nxt = start;
      e.x = (m_prev_rdy && m_prev_valid) ? m_prev_d : '0;
      e.und = m_und; e.fin = m_fin;
      e.ovr = m_ovr; e.fout = m_fout;
      e.ov = m_po_v; e.of = m_po_f; e.ol = m_po_l; e.od = m_po_d;
      q.push_back(e);
      // input side, next cycle
      m_und = (rdy && !v) || (m_und && !c);
      if (rdy && beat == FB - 1) m_fin++;
      if (rdy && v) m_j++;
      m_prev_rdy = rdy; m_prev_valid = v; m_prev_d = d; m_prev_rst = 1'b0;
      // output side, next cycle
      rise   = cn && !m_prev_cno;
      sbeat  = m_cyc - m_cs - 1;
      in_win = (sbeat >= 0) && (sbeat < FB);
      if (m_po_l) m_fout++;
      m_ovr  = (rise && in_win) || (m_ovr && !c);
      m_po_v = in_win;
      m_po_f = in_win && (sbeat == 0);
      m_po_l = in_win && (sbeat == FB - 1);
      m_po_d = y;
      if (rise) m_cs = m_cyc;
      m_prev_cno = cn;
    end
  endtask

  // monitor: compare every presented cycle against the queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      mon_cyc++;
      chk("in_ready",   W'(bus.in_ready), W'(me.rdy));
      chk("core_next",  W'(bus.core_next), W'(me.nxt));
      chk("core_x",     {bus.core_x3, bus.core_x2, bus.core_x1, bus.core_x0}, me.x);
      chk("underrun",   W'(bus.underrun), W'(me.und));
      chk("overrun",    W'(bus.overrun), W'(me.ovr));
      chk("frames_in",  W'(bus.frames_in), W'(me.fin));
      chk("frames_out", W'(bus.frames_out), W'(me.fout));
      chk("out_valid",  W'(bus.out_valid), W'(me.ov));
      chk("out_first",  W'(bus.out_first), W'(me.of));
      chk("out_last",   W'(bus.out_last), W'(me.ol));
      if (me.ov)
        chk("out_d", {bus.out_d3, bus.out_d2, bus.out_d1, bus.out_d0}, me.od);
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.clr_err = 1'b0; bus.core_next_out = 1'b0;
    bus.in_d0 = '0; bus.in_d1 = '0; bus.in_d2 = '0; bus.in_d3 = '0;
    bus.core_y0 = '0; bus.core_y1 = '0; bus.core_y2 = '0; bus.core_y3 = '0;

    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

    // two back-to-back frames with counting data; capture edge at i=40 and a
    // second edge at capture beat 300
    for (int i = 0; i < 5800; i++)
      step(1'b0, 1'b1, 1'b0, (i == 40) || (i == 41) || (i == 341));

    // third frame loses beat 100 (clear in the same cycle must lose), then clear
    g_drop_beat = 100; g_clr_on_drop = 1'b1;
    for (int i = 0; i < 5100; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    g_drop_beat = -1; g_clr_on_drop = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // randomized traffic on both paths
    g_rand_data = 1'b1; g_y_rand = 1'b1;
    for (int i = 0; i < 16000; i++)
      step(1'b0, $urandom_range(0, 19) != 0, $urandom_range(0, 399) == 0,
           $urandom_range(0, 899) == 0);

    // reset at load beat 200, then a new frame must start right away
    g_rand_data = 1'b0;
    g_reset_beat = 200;
    for (int i = 0; i < 12000 && !g_reset_hit; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    g_reset_beat = -1;
    n_checks++;
    if (g_reset_hit) n_pass++;
    else $display("FAIL reset_at_beat200: got not reached expected reached");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) step(1'b0, 1'b1, 1'b0, i == 10);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
